// File: rtl/acc_capture_pkg.sv
// Shared types for the qubit accumulator capture path: FSM state encoding and
// the default width of the dropped-result counter.
package qubic_acc_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_RUN   = 3'd2,
      S_WRX   = 3'd3,
      S_WRY   = 3'd4,
      S_FULL  = 3'd5
   } acc_state_t;

   localparam int DROPW_DEFAULT = 16;

endpackage

// File: rtl/acc_capture_if.sv
// Result/buffer bundle between a meas2 instance, acc_capture and the dpram port A.
// master drives results and observes writes; slave is the capture stage.
interface acc_capture_if #(
   parameter int DW = 32,
   parameter int AW = 12
) ();
   logic          done;
   logic [DW-1:0] xacc;
   logic [DW-1:0] yacc;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   modport master (output done, xacc, yacc, input wr_en, wr_addr, wr_data);
   modport slave  (input done, xacc, yacc, output wr_en, wr_addr, wr_data);
endinterface

// File: rtl/acc_capture_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);
   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_q;

   // next count: clear, saturating increment, or hold
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign q = cnt_q;
endmodule

// File: rtl/acc_capture.sv
// Capture stage: after start+trig, writes each (xacc, yacc) result as an x/y word
// pair into the accumulation buffer until it fills; counts results it cannot take.
module acc_capture
   import qubic_acc_pkg::*;
#(
   parameter int DW    = 32,
   parameter int AW    = 12,
   parameter int DROPW = DROPW_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             trig,
   acc_capture_if.slave     bus,
   output logic             armed,
   output logic             running,
   output logic             full,
   output logic [AW:0]      count,
   output logic [DROPW-1:0] dropped
);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   acc_state_t    state_d, state_q;
   logic [AW:0]   ptr_d, ptr_q;
   logic [DW-1:0] x_d, x_q, y_d, y_q;
   logic          drop_inc;
   logic          wr_en_d, wr_en_q;
   logic [AW-1:0] wr_addr_d, wr_addr_q;
   logic [DW-1:0] wr_data_d, wr_data_q;
   logic          armed_d, armed_q, running_d, running_q, full_d, full_q;

   // next state, pointer, result latch and drop detection; start overrides everything
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      x_d      = x_q;
      y_d      = y_q;
      drop_inc = 1'b0;
      if (start) begin
         state_d = S_ARMED;
         ptr_d   = '0;
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_ARMED: begin
               if (trig) state_d = S_RUN;
               else      state_d = S_ARMED;
            end
            S_RUN: begin
               if (bus.done) begin
                  x_d     = bus.xacc;
                  y_d     = bus.yacc;
                  state_d = S_WRX;
               end else begin
                  state_d = S_RUN;
               end
            end
            S_WRX: begin
               ptr_d    = ptr_q + PTR_ONE;
               drop_inc = bus.done;
               state_d  = S_WRY;
            end
            S_WRY: begin
               ptr_d    = ptr_q + PTR_ONE;
               drop_inc = bus.done;
               if (ptr_d[AW]) state_d = S_FULL;
               else           state_d = S_RUN;
            end
            S_FULL: begin
               drop_inc = bus.done;
               state_d  = S_FULL;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // outputs are decoded from the next state so the registered copies line up with it
   always_comb begin
      wr_en_d   = (state_d == S_WRX) || (state_d == S_WRY);
      wr_addr_d = ptr_d[AW-1:0];
      if (state_d == S_WRX)      wr_data_d = x_d;
      else if (state_d == S_WRY) wr_data_d = y_d;
      else                       wr_data_d = '0;
      armed_d   = (state_d == S_ARMED);
      running_d = (state_d == S_RUN) || (state_d == S_WRX) || (state_d == S_WRY);
      full_d    = (state_d == S_FULL);
   end

   // state, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         armed_q   <= 1'b0;
         running_q <= 1'b0;
         full_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         x_q       <= x_d;
         y_q       <= y_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         armed_q   <= armed_d;
         running_q <= running_d;
         full_q    <= full_d;
      end
   end

   sat_cnt #(.W(DROPW)) u_drop_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (start),
      .inc     (drop_inc),
      .q       (dropped)
   );

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign armed       = armed_q;
   assign running     = running_q;
   assign full        = full_q;
   assign count       = ptr_q;
endmodule

// File: doc/acc_capture.md
# acc_capture

Measurement-result capture stage sitting directly downstream of each `meas2` instance in the qubit DSP top level. Consumes the `done` pulse and the `xacc`/`yacc` accumulator results. Writes them as interleaved x/y words into port A of an external accumulation `dpram`, which the localbus reads back on port B. Capture is armed by a localbus start strobe and begins at the next period trigger. Writes stop when the buffer fills, and drops are counted.

## Interface
Parameters:
- `DW`, 32, accumulator word width
- `AW`, 12, buffer address width; depth 2^AW words, i.e. 2^(AW-1) shots
- `DROPW`, 16, width of the dropped-result counter

Ports:
- `clk`  in  1  DSP clock; all logic on its rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle arm strobe (`stb_start`, already in the `clk` domain)
- `trig`  in  1  one-cycle period boundary (`trig_chan`)
- `done`  in  1  one-cycle result-valid pulse from `meas2`
- `xacc`  in  DW  x result; valid in the `done` cycle
- `yacc`  in  DW  y result; valid in the `done` cycle
- `wr_en`  out  1  buffer write enable (drives `wena`)
- `wr_addr`  out  AW  buffer write address
- `wr_data`  out  DW  buffer write data
- `armed`  out  1  waiting for first `trig` after `start`
- `running`  out  1  capturing
- `full`  out  1  buffer full; no further writes
- `count`  out  AW+1  words written since the last `start`
- `dropped`  out  DROPW  results discarded since the last `start`; saturates at all-ones

## Operation
- State machine states: IDLE, ARMED, RUN, WRX, WRY, FULL.
- Reset (`reset_n`=0): state IDLE. All outputs are 0, including `wr_en`, `wr_addr`, `wr_data`, `count`, `dropped` and `full`.
- IDLE: no writes. `done` is ignored and not counted.
- `start` from any state: go to ARMED; clear `count`, the internal pointer `ptr` and `dropped`; deassert `full`. An in-flight write pair is abandoned; a pending y write is not issued.
- ARMED: `trig` moves to RUN. `done` is ignored and not counted. `start`+`trig` in the same cycle: `start` wins; the state stays ARMED and waits for the next `trig`.
- RUN: on `done`, latch `xacc` and `yacc`, then go to WRX.
- WRX: assert `wr_en` with `wr_addr`=`ptr` and `wr_data`=latched x. Increment `ptr`, then go to WRY.
- WRY: assert `wr_en` with `wr_addr`=`ptr` and `wr_data`=latched y. Increment `ptr`. Go to FULL if `ptr` becomes 2^AW, else to RUN.
- A `done` seen in WRX or WRY is not captured. It increments `dropped` (saturating).
- FULL: `full`=1 and `wr_en`=0. Each `done` increments `dropped` (saturating). Leave FULL only via `start` or reset.
- `count` = `ptr`, which is AW+1 bits wide. x always lands at an even address and y at an odd address.
- `trig` has no effect in RUN, WRX, WRY or FULL; capture spans multiple periods.

## Timing
- `done` at cycle t: x write in cycle t+1 (address N), y write in cycle t+2 (address N+1).
- `wr_en`, `wr_addr` and `wr_data` are registered outputs.
- `count` steps at the end of each write cycle: N+1 in t+2, N+2 in t+3.
- `full` rises in the cycle after the last y write.
- Minimum `done` spacing for loss-free capture: 3 cycles.
- Status outputs are registered and reflect the state:
  - `armed`=1 in ARMED
  - `running`=1 in RUN, WRX and WRY
- `start` at cycle t: `armed`=1 and `count`=0 from t+1.
- `trig` in ARMED at cycle t: `running`=1 from t+1, so a `done` at t+1 is captured.
- `reset_n` low mid-operation: all outputs return to reset values at the next edge.

## Structure
- Shared package `qubic_acc_pkg`: state enum `acc_state_t` and the localparam for the default `DROPW`.
- One sub-module: `sat_cnt` (width parameter; synchronous clear; saturating increment), used for `dropped`.
- The `dpram` is instantiated by the parent, not inside this block.

## Test plan
- Reset, then `done` pulses with no `start` -> `wr_en` never asserts; `count`=0, `dropped`=0.
- AW=3: `start`, `trig`, then 4 `done` pulses 5 cycles apart with x=0x11*k and y=0x22*k (k=1..4):
  - addresses 0..7 receive 0x11, 0x22, 0x22, 0x44, 0x33, 0x66, 0x44, 0x88
  - `full`=1 the cycle after the address-7 write
  - `count`=8
- After the full case above: 3 more `done` pulses -> no writes; `dropped`=3.
- `done` at t, then again at t+1 and t+2 -> only the first is captured (2 writes); `dropped`=2.
- `start` and `trig` in the same cycle, then `done` -> no write. After the next `trig`, a `done` writes to address 0.
- `start` issued in WRX -> no y write follows; `count`=0 and `armed`=1 on the next cycle.
- DROPW=2: 5 `done` pulses while FULL -> `dropped` saturates at 3.
